// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central hazard/stall sequencer for the five-stage pipeline. It owns the
// SRAM access FSM and merges memory stalls, taken branches and RAW hazards
// into freeze / bubble / flush controls. It also keeps saturating
// performance counters for stalled and flushed cycles.
// The control outputs are combinational and are gated to 0 while reset is
// held, so the pipeline never sees a stray strobe during reset.
module pipeline_stall_controller #(
  parameter int REGFILE_ADDRESS_LEN = 4,
  parameter int WAIT_CYCLES         = 3,
  parameter int FORWARDING_EN       = 1,
  parameter int CNT_LEN             = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
  input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
  input  logic                           id_two_src,
  input  logic [REGFILE_ADDRESS_LEN-1:0] exe_dest,
  input  logic                           exe_wb_en,
  input  logic                           exe_mem_read,
  input  logic [REGFILE_ADDRESS_LEN-1:0] mem_dest,
  input  logic                           mem_wb_en,
  input  logic                           mem_req,
  input  logic                           branch_taken,
  output logic                           freeze,
  output logic                           id_bubble,
  output logic                           flush,
  output logic                           mem_stall,
  output logic                           sram_start,
  output logic                           mem_done,
  output logic [CNT_LEN-1:0]             stall_count,
  output logic [CNT_LEN-1:0]             flush_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last value of the wait counter before the access completes.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};
  localparam logic [CNT_LEN-1:0] CNT_ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] wait_cnt_r;
  logic [3:0] wait_cnt_next_s;

  logic stall_raw_s;
  logic start_raw_s;
  logic done_raw_s;
  logic exe_match_s;
  logic mem_match_s;
  logic raw_hazard_s;
  logic mem_stall_s;
  logic flush_s;
  logic bubble_s;
  logic freeze_s;

  // SRAM FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // SRAM FSM next-state and raw (ungated) strobes.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    stall_raw_s     = 1'b0;
    start_raw_s     = 1'b0;
    done_raw_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          stall_raw_s     = 1'b1;
          start_raw_s     = 1'b1;
          wait_cnt_next_s = 4'd0;
          state_next_s    = ACCESS;
        end else begin
          state_next_s    = IDLE;
        end
      end
      ACCESS: begin
        stall_raw_s     = 1'b1;
        wait_cnt_next_s = wait_cnt_r + 4'd1;
        if (wait_cnt_r == WAIT_LAST) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      DONE: begin
        done_raw_s   = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // RAW hazard detection between ID sources and later-stage destinations.
  always_comb begin
    exe_match_s = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    mem_match_s = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
    if (FORWARDING_EN != 0) begin
      // With forwarding only a load in EXE cannot supply its result in time.
      raw_hazard_s = exe_match_s && exe_wb_en && exe_mem_read;
    end else begin
      raw_hazard_s = (exe_match_s && exe_wb_en) || (mem_match_s && mem_wb_en);
    end
  end

  // Priority merge: memory stall over flush over hazard bubble, all held low in reset.
  always_comb begin
    mem_stall_s = stall_raw_s && rst;
    flush_s     = branch_taken && !stall_raw_s && rst;
    bubble_s    = raw_hazard_s && !stall_raw_s && !flush_s && rst;
    freeze_s    = mem_stall_s || bubble_s;
  end

  assign mem_stall  = mem_stall_s;
  assign flush      = flush_s;
  assign id_bubble  = bubble_s;
  assign freeze     = freeze_s;
  assign sram_start = start_raw_s && rst;
  assign mem_done   = done_raw_s && rst;

  // Saturating count of frozen cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= {CNT_LEN{1'b0}};
    end else if (freeze_s && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

  // Saturating count of flushed cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count <= {CNT_LEN{1'b0}};
    end else if (flush_s && (flush_count != CNT_MAX)) begin
      flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller. Two instances share the
// stimulus: dut A uses the defaults (forwarding, 16-bit counters) and dut B
// has forwarding disabled and 4-bit counters so that saturation is reachable.
// The stimulus pushes the hand-computed output vector of each cycle into a
// queue, and the monitor pops and compares it in the middle of that cycle.
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, mem_req, branch_taken;

  logic        a_freeze, a_id_bubble, a_flush, a_mem_stall, a_sram_start, a_mem_done;
  logic [15:0] a_stall_count, a_flush_count;
  logic        b_freeze, b_id_bubble, b_flush, b_mem_stall, b_sram_start, b_mem_done;
  logic [3:0]  b_stall_count, b_flush_count;

  // Output vector order: {freeze, id_bubble, flush, mem_stall, sram_start, mem_done}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] STRT = 6'b100110;
  localparam logic [5:0] ACC  = 6'b100100;
  localparam logic [5:0] DON  = 6'b000001;
  localparam logic [5:0] DONF = 6'b001001;
  localparam logic [5:0] BUB  = 6'b110000;
  localparam logic [5:0] FLS  = 6'b001000;

  typedef struct {
    int          step;
    int          dut;
    logic [5:0]  exp_out;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } rec_t;

  rec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;
  int   model_sa = 0, model_fa = 0, model_sb = 0, model_fb = 0;

  pipeline_stall_controller #(
    .REGFILE_ADDRESS_LEN(4), .WAIT_CYCLES(3), .FORWARDING_EN(1), .CNT_LEN(16)
  ) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze(a_freeze), .id_bubble(a_id_bubble), .flush(a_flush), .mem_stall(a_mem_stall),
    .sram_start(a_sram_start), .mem_done(a_mem_done),
    .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  pipeline_stall_controller #(
    .REGFILE_ADDRESS_LEN(4), .WAIT_CYCLES(3), .FORWARDING_EN(0), .CNT_LEN(4)
  ) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze(b_freeze), .id_bubble(b_id_bubble), .flush(b_flush), .mem_stall(b_mem_stall),
    .sram_start(b_sram_start), .mem_done(b_mem_done),
    .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                       input logic [3:0] ed, input logic ewb, input logic emr,
                       input logic [3:0] md, input logic mwb, input logic mreq, input logic br);
    id_src1 = s1; id_src2 = s2; id_two_src = two;
    exe_dest = ed; exe_wb_en = ewb; exe_mem_read = emr;
    mem_dest = md; mem_wb_en = mwb; mem_req = mreq; branch_taken = br;
  endtask

  // Queue this cycle's expectations for both instances, then advance one clock.
  task automatic cyc(input logic [5:0] ea, input logic [5:0] eb);
    rec_t r;
    if (rst == 1'b0) begin
      model_sa = 0; model_fa = 0; model_sb = 0; model_fb = 0;
    end
    r.step = step_no; r.dut = 0; r.exp_out = ea;
    r.exp_stall = 16'(model_sa); r.exp_flush = 16'(model_fa);
    q.push_back(r);
    r.dut = 1; r.exp_out = eb;
    r.exp_stall = 16'(model_sb); r.exp_flush = 16'(model_fb);
    q.push_back(r);
    if (rst == 1'b1) begin
      model_sa = sat(model_sa + int'(ea[5]), 65535);
      model_fa = sat(model_fa + int'(ea[3]), 65535);
      model_sb = sat(model_sb + int'(eb[5]), 15);
      model_fb = sat(model_fb + int'(eb[3]), 15);
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, compare every pending expectation against the DUT.
  initial begin
    rec_t        r;
    logic [5:0]  act;
    logic [15:0] act_s, act_f;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        r = q.pop_front();
        if (r.dut == 0) begin
          act   = {a_freeze, a_id_bubble, a_flush, a_mem_stall, a_sram_start, a_mem_done};
          act_s = a_stall_count;
          act_f = a_flush_count;
        end else begin
          act   = {b_freeze, b_id_bubble, b_flush, b_mem_stall, b_sram_start, b_mem_done};
          act_s = {12'd0, b_stall_count};
          act_f = {12'd0, b_flush_count};
        end
        vectors++;
        if ((act !== r.exp_out) || (act_s !== r.exp_stall) || (act_f !== r.exp_flush)) begin
          miscompares++;
          $display("FAIL step%0d dut%s: got out=%b stall=%0d flush=%0d, expected out=%b stall=%0d flush=%0d",
                   r.step, (r.dut == 0) ? "A" : "B", act, act_s, act_f,
                   r.exp_out, r.exp_stall, r.exp_flush);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0;
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    // Reset held with active inputs: everything low.
    cyc(NONE, NONE);
    cyc(NONE, NONE);
    drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(NONE, NONE);

    // Single access with mem_req held, then an immediate second access.
    drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(STRT, STRT);
    for (int i = 0; i < 3; i++) cyc(ACC, ACC);
    cyc(DON, DON);
    // Second access with a branch held in EXE throughout the stall.
    branch_taken = 1'b1;
    cyc(STRT, STRT);
    for (int i = 0; i < 3; i++) cyc(ACC, ACC);
    mem_req = 1'b0;
    cyc(DONF, DONF);
    branch_taken = 1'b0;
    cyc(NONE, NONE);

    // Load-use and RAW cases.
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(BUB, BUB);
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(NONE, BUB);
    drive(4'd0, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(NONE, NONE);
    drive(4'd0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(BUB, BUB);
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(NONE, NONE);
    // Pending write in MEM: only matters without forwarding.
    drive(4'd7, 4'd2, 1'b1, 4'd9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(NONE, BUB);
    drive(4'd7, 4'd2, 1'b0, 4'd9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(NONE, NONE);
    drive(4'd2, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(NONE, BUB);
    // Branch together with a load-use match: flush wins.
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(FLS, FLS);

    // Access started with a hazard present; reset lands in ACCESS.
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(STRT, STRT);
    cyc(ACC, ACC);
    rst = 1'b0;
    cyc(NONE, NONE);
    rst = 1'b1;
    cyc(STRT, STRT);
    drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(ACC, ACC);
    mem_req = 1'b0;
    cyc(DON, DON);
    cyc(NONE, NONE);

    // Freeze held 20 cycles: dut B's 4-bit stall counter pins at 15.
    drive(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(BUB, BUB);
    drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(NONE, NONE);
    cyc(NONE, NONE);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central hazard and stall sequencer for the five-stage ARM pipeline. Combines three inputs into the freeze, bubble and flush controls that the IF, ID, EXE and MEM stages and their pipeline registers consume:
- load-use / RAW hazards detected between ID and the later stages;
- taken branches resolved in EXE;
- multi-cycle SRAM accesses issued from MEM.

It also owns the SRAM access FSM and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- REGFILE_ADDRESS_LEN, 4, register-file address width
- WAIT_CYCLES, 3, SRAM access cycles after the start cycle; legal range 1..15
- FORWARDING_EN, 1, 1 = only load-use stalls; 0 = any pending write to a source stalls
- CNT_LEN, 16, performance counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_src1  in  REGFILE_ADDRESS_LEN  Rn of instruction in ID
- id_src2  in  REGFILE_ADDRESS_LEN  Rm/Rd source of instruction in ID
- id_two_src  in  1  instruction in ID reads id_src2
- exe_dest  in  REGFILE_ADDRESS_LEN  destination of instruction in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  REGFILE_ADDRESS_LEN  destination of instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- mem_req  in  1  MEM instruction reads or writes memory
- branch_taken  in  1  EXE resolved a taken branch
- freeze  out  1  hold PC and IF/ID register
- id_bubble  out  1  ID/EXE register loads a NOP (control bits zero)
- flush  out  1  clear IF/ID and ID/EXE registers
- mem_stall  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
- sram_start  out  1  one-cycle SRAM access strobe
- mem_done  out  1  SRAM data valid; MEM/WB captures this cycle
- stall_count  out  CNT_LEN  saturating count of cycles with freeze=1
- flush_count  out  CNT_LEN  saturating count of cycles with flush=1

## Operation
- **SRAM FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - mem_req=1 drives mem_stall=1 and sram_start=1 combinationally, loads wait counter to 0 and moves to ACCESS.
  - mem_req=0 keeps IDLE with no outputs.
- **ACCESS:**
  - mem_stall=1 and sram_start=0; the counter increments each cycle.
  - When counter==WAIT_CYCLES-1, go to DONE.
- **DONE:** mem_stall=0 and mem_done=1; the pipeline advances at this edge; unconditionally go to IDLE.
- **raw_hazard:**
  - Match condition: id_src1 matches, or id_two_src=1 and id_src2 matches.
  - FORWARDING_EN=1: the match is against exe_dest with exe_wb_en & exe_mem_read.
  - FORWARDING_EN=0: the match is against exe_dest with exe_wb_en, or mem_dest with mem_wb_en.
- **Priority:** mem_stall > flush > raw_hazard.
  - flush = branch_taken & ~mem_stall. A branch held in EXE during a stall flushes only in the cycle the pipeline advances.
  - id_bubble = raw_hazard & ~mem_stall & ~flush.
  - freeze = mem_stall | id_bubble.
- **Counters:** increment on clk when the condition holds and saturate at all-ones; they never wrap.

## Timing
- **Reset (rst=0, asynchronous):**
  - FSM returns to IDLE and the wait counter and both perf counters clear to 0.
  - All outputs are 0 while reset is asserted, regardless of inputs.
- **Reset mid-access:** FSM returns to IDLE immediately and sram_start/mem_done are not reissued. After rst rises, a still-asserted mem_req starts a fresh access.
- **Access length:** stall cycles per access = 1 + WAIT_CYCLES. mem_done arrives in cycle WAIT_CYCLES+1 after the IDLE request cycle (cycle 0).
- **Back-to-back accesses:** a new mem_req is first seen in the IDLE cycle after DONE, giving at least one non-stalled cycle between accesses.
- **Combinational outputs:** flush, id_bubble and freeze are combinational from inputs and state, with no added latency. The hazard bubble lasts exactly one cycle for a load-use case.
- **Simultaneous events:**
  - branch_taken with raw_hazard and no stall gives flush=1, id_bubble=0, freeze=0.
  - branch_taken during ACCESS gives flush=0 until the DONE cycle.

## Test plan
- **Reset mid-access:** release reset, then assert rst=0 during ACCESS → all outputs 0 immediately, FSM in IDLE, counters 0.
- **Single access:** WAIT_CYCLES=3, mem_req held from cycle 0 → sram_start=1 in cycle 0 only, mem_stall=1 in cycles 0-3, mem_done=1 in cycle 4 with mem_stall=0, stall_count=4.
- **Load-use:** FORWARDING_EN=1, exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5 → id_bubble=1, freeze=1 for one cycle. With exe_mem_read=0 → no bubble.
- **No forwarding:** FORWARDING_EN=0, mem_wb_en=1, mem_dest=2, id_two_src=1, id_src2=2 → id_bubble=1. With id_two_src=0 → id_bubble=0.
- **Branch during stall:** branch_taken=1 asserted during ACCESS → flush=0 through the stall and flush=1 in the DONE cycle, so flush_count=1. Separately, branch_taken=1 together with a load-use match and no stall → flush=1, id_bubble=0.
- **Saturation:** CNT_LEN=4, freeze held 20 cycles → stall_count stops at 15.
